cpu_seq_ctrl: RTL

Parametrised multi-cycle instruction sequencer for the 16-bit CPU family; next generation of the fixed 4-step controller.
- Owns the program-load path, the per-instruction step counter, one-hot stage enables, instruction latch, halt/done handling, a single-step debug mode and a saturating cycle timer.
- Sits between the memory/datapath and the decode logic; the datapath consumes stage_en/pc_en, and the decode logic supplies halt_ins and execute-phase memory requests.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/seq_step_counter.sv | 36 +++
 rtl/cpu_seq_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencer family.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  localparam logic [2:0]  STEP_FETCH = 3'd0;
  localparam int unsigned DEF_DW     = 16;
  localparam int unsigned DEF_AW     = 8;
  localparam int unsigned DEF_STEPS  = 4;
  localparam int unsigned DEF_TW     = 16;

  function automatic bit steps_legal(input int unsigned s);
    return (s >= 2) && (s <= 8);
  endfunction

endpackage

// File: rtl/seq_step_counter.sv
// Per-instruction step counter: wraps at STEPS-1, flags the last step and
// decodes a one-hot stage enable that is all-zero while disabled.
module seq_step_counter
  import cpu_pkg::*;
#(
  parameter int unsigned STEPS = DEF_STEPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [2:0]       step,
  output logic             last,
  output logic [STEPS-1:0] onehot
);

  assign last = (step == 3'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= STEP_FETCH;
    end else if (clr) begin
      step <= STEP_FETCH;
    end else if (en) begin
      step <= last ? STEP_FETCH : step + 3'd1;
    end
  end

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      onehot[i] = en && (step == 3'(i));
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: program load, fetch/execute stepping,
// halt/done, single-step debug and a saturating RUN-cycle timer.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned STEPS = DEF_STEPS,
  parameter int unsigned TW    = DEF_TW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ext_wen,
  input  logic [AW-1:0]    ext_addr,
  input  logic [DW-1:0]    ext_data,
  input  logic             test_normal,
  input  logic             step_req,
  input  logic             halt_ins,
  input  logic [AW-1:0]    pc_addr,
  input  logic [AW-1:0]    exe_addr,
  input  logic [DW-1:0]    exe_data,
  input  logic             exe_wen,
  input  logic [DW-1:0]    mem_rdata,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_data,
  output logic [2:0]       step,
  output logic [STEPS-1:0] stage_en,
  output logic             pc_en,
  output logic [DW-1:0]    ins,
  output logic             ins_valid,
  output logic             busy,
  output logic             done,
  output logic [TW-1:0]    cycle_cnt
);

  if (!steps_legal(STEPS)) begin : g_steps_check
    $error("cpu_seq_ctrl: STEPS must be in 2..8");
  end

  state_t state;
  logic   run;
  logic   last;
  logic   fetch;
  logic   load;

  assign run   = (state == ST_RUN);
  assign fetch = (step == STEP_FETCH);
  // Gating with rst_n keeps every strobe quiet the instant reset asserts.
  assign load  = ext_wen && rst_n;

  seq_step_counter #(
    .STEPS(STEPS)
  ) u_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ext_wen || !run),
    .en     (run),
    .step   (step),
    .last   (last),
    .onehot (stage_en)
  );

  assign busy  = (state == ST_RUN) || (state == ST_PAUSE);
  assign done  = (state == ST_DONE);
  assign pc_en = run && last && !halt_ins && !load;

  // Loading takes the memory port in any state, which also aborts an
  // in-flight execute write.
  always_comb begin
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (load) begin
      mem_wen  = 1'b1;
      mem_addr = ext_addr;
      mem_data = ext_data;
    end else if (run && fetch) begin
      mem_addr = pc_addr;
    end else if (run) begin
      mem_addr = exe_addr;
      mem_data = exe_data;
      mem_wen  = last && exe_wen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ins       <= '0;
      ins_valid <= 1'b0;
      cycle_cnt <= '0;
    end else if (ext_wen) begin
      state     <= ST_LOAD;
      ins_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            cycle_cnt <= '0;
          end
        end
        ST_LOAD: state <= ST_IDLE;
        ST_RUN: begin
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
          if (fetch) begin
            ins       <= mem_rdata;
            ins_valid <= 1'b1;
          end
          if (last) begin
            if (halt_ins) begin
              state <= ST_DONE;
            end else begin
              ins_valid <= 1'b0;
              state     <= test_normal ? ST_PAUSE : ST_RUN;
            end
          end
        end
        ST_PAUSE: begin
          if (step_req || !test_normal) state <= ST_RUN;
        end
        ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            cycle_cnt <= '0;
            ins_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
